// File: rtl/axis_pixel_transmitter.sv
// -----------------------------------------------------------------------------
// axis_pixel_transmitter
//
// Buffers filtered pixels from a non-backpressurable upstream stage in a small
// FIFO and presents them as an AXI4-Stream with frame and line markers.
//   tuser - start of frame (carried through the FIFO with each pixel)
//   tlast - end of line (derived at the output from a column counter)
//
// Ports:
//   i_clk             clock, all logic on rising edge
//   i_aresetn         synchronous active-low reset
//   IMAGE_WIDTH       runtime pixels per line (0 treated as 1)
//   i_data            input pixel
//   i_data_valid      input pixel valid (no upstream backpressure)
//   i_start_of_frame  marks the first pixel of a frame
//   m_axis_tdata      output pixel
//   m_axis_tvalid     output valid (FIFO non-empty)
//   m_axis_tready     downstream ready
//   m_axis_tuser      start of frame
//   m_axis_tlast      end of line
//   o_fifo_level      FIFO occupancy, 0..FIFO_DEPTH
//   o_overflow        sticky flag, set when a pixel is dropped
// -----------------------------------------------------------------------------
module axis_pixel_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_aresetn,
    input  logic [15:0]                   IMAGE_WIDTH,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_data_valid,
    input  logic                          i_start_of_frame,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(FIFO_DEPTH);

    // Each entry is {start_of_frame, pixel}
    logic [EW-1:0]          mem_q [FIFO_DEPTH];

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            col_q, col_d;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic                   push_ok;
    logic                   head_user;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [15:0]            width_eff;
    logic [15:0]            head_col;
    logic                   head_last;

    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_FULL);

        {head_user, head_data} = mem_q[rd_ptr_q];

        pop     = !fifo_empty && m_axis_tready;
        // A full FIFO can still accept when the head leaves on the same edge
        push_ok = i_data_valid && (!fifo_full || pop);

        width_eff = (IMAGE_WIDTH == 16'd0) ? 16'd1 : IMAGE_WIDTH;
        // A start-of-frame beat always sits in column 0, even mid-line
        head_col  = head_user ? 16'd0 : col_q;
        head_last = !fifo_empty && (head_col >= (width_eff - 16'd1));

        m_axis_tvalid = !fifo_empty;
        m_axis_tdata  = fifo_empty ? '0 : head_data;
        m_axis_tuser  = !fifo_empty && head_user;
        m_axis_tlast  = head_last;
        o_fifo_level  = level_q;
        o_overflow    = overflow_q;

        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q | (i_data_valid && fifo_full && !pop);

        col_d = col_q;
        if (pop) begin
            col_d = head_last ? 16'd0 : (head_col + 16'd1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            col_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            col_q      <= col_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid
    always_ff @(posedge i_clk) begin
        if (i_aresetn && push_ok) begin
            mem_q[wr_ptr_q] <= {i_start_of_frame, i_data};
        end
    end

endmodule

// File: tb/tb_axis_pixel_transmitter.sv
// -----------------------------------------------------------------------------
// tb_axis_pixel_transmitter
//
// Directed stimulus with a scoreboard: each pushed pixel that must reach the
// output has its expected {tuser, tlast, tdata} queued; a monitor pops and
// compares on every accepted output beat.
// -----------------------------------------------------------------------------
module tb_axis_pixel_transmitter;

    logic        i_clk;
    logic        i_aresetn;
    logic [15:0] IMAGE_WIDTH;
    logic [7:0]  i_data;
    logic        i_data_valid;
    logic        i_start_of_frame;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic [4:0]  o_fifo_level;
    logic        o_overflow;

    axis_pixel_transmitter #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16)
    ) dut (
        .i_clk            (i_clk),
        .i_aresetn        (i_aresetn),
        .IMAGE_WIDTH      (IMAGE_WIDTH),
        .i_data           (i_data),
        .i_data_valid     (i_data_valid),
        .i_start_of_frame (i_start_of_frame),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tlast     (m_axis_tlast),
        .o_fifo_level     (o_fifo_level),
        .o_overflow       (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [9:0] exp_q[$];   // {tuser, tlast, tdata}
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one pixel for one edge; optionally queue its expected output beat
    task automatic push(input logic [7:0] d, input logic sof, input logic u_exp,
                        input logic l_exp, input logic expect_out);
        if (expect_out) exp_q.push_back({u_exp, l_exp, d});
        i_data           = d;
        i_start_of_frame = sof;
        i_data_valid     = 1'b1;
        @(posedge i_clk); #1;
        i_data_valid     = 1'b0;
        i_start_of_frame = 1'b0;
    endtask

    task automatic do_reset();
        m_axis_tready = 1'b0;
        i_data_valid  = 1'b0;
        i_aresetn     = 1'b0;
        @(posedge i_clk); #1;
        i_aresetn     = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 200 && o_fifo_level != 0; i++) begin
            @(posedge i_clk); #1;
        end
        check({name, "_level0"}, 32'(o_fifo_level), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare every accepted beat against the scoreboard
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (!m_axis_tvalid) begin
                checks++;
                if (m_axis_tlast || m_axis_tuser) begin
                    errors++;
                    $display("FAIL idle_markers: tuser=%0d tlast=%0d required 0 0",
                             m_axis_tuser, m_axis_tlast);
                end
            end
            if (i_aresetn && m_axis_tvalid && m_axis_tready) begin
                checks++;
                $display("beat data=0x%02h tuser=%0d tlast=%0d",
                         m_axis_tdata, m_axis_tuser, m_axis_tlast);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got data=0x%02h, none expected",
                             m_axis_tdata);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== e) begin
                        errors++;
                        $display("FAIL beat: got u=%0d l=%0d d=0x%02h expected u=%0d l=%0d d=0x%02h",
                                 m_axis_tuser, m_axis_tlast, m_axis_tdata, e[9], e[8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_aresetn        = 1'b0;
        IMAGE_WIDTH      = 16'd4;
        i_data           = '0;
        i_data_valid     = 1'b0;
        i_start_of_frame = 1'b0;
        m_axis_tready    = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
        check("rst_tdata",    32'(m_axis_tdata),  32'd0);
        check("rst_tuser",    32'(m_axis_tuser),  32'd0);
        check("rst_tlast",    32'(m_axis_tlast),  32'd0);
        check("rst_level",    32'(o_fifo_level),  32'd0);
        check("rst_overflow", 32'(o_overflow),    32'd0);
        i_aresetn = 1'b1;
        mon_en    = 1'b1;

        // Basic stream, width 4, one-cycle latency
        IMAGE_WIDTH   = 16'd4;
        m_axis_tready = 1'b1;
        push(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        check("lat_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("lat_tdata",  32'(m_axis_tdata),  32'h01);
        check("lat_tuser",  32'(m_axis_tuser),  32'd1);
        for (int i = 2; i <= 8; i++) begin
            push(8'(i), 1'b0, 1'b0, (i == 4 || i == 8), 1'b1);
        end
        drain("basic");

        // Backpressure: 6 pixels held for 10 cycles
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            push(8'(i), (i == 1), (i == 1), (i == 4), 1'b1);
            check("bp_head", 32'(m_axis_tdata), 32'h01);
        end
        repeat (4) begin
            @(posedge i_clk); #1;
            check("bp_hold_data",  32'(m_axis_tdata),  32'h01);
            check("bp_hold_valid", 32'(m_axis_tvalid), 32'd1);
        end
        check("bp_level", 32'(o_fifo_level), 32'd6);
        drain("bp");
        check("bp_overflow", 32'(o_overflow), 32'd0);

        // Overflow: 18 pushes into a 16-deep FIFO
        do_reset();
        IMAGE_WIDTH = 16'd16;
        for (int i = 1; i <= 16; i++) begin
            push(8'(i), (i == 1), (i == 1), (i == 16), 1'b1);
        end
        check("ovf_before",  32'(o_overflow),   32'd0);
        check("ovf_level16", 32'(o_fifo_level), 32'd16);
        push(8'd17, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(o_overflow), 32'd1);
        push(8'd18, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_level_hold", 32'(o_fifo_level), 32'd16);
        check("ovf_head",       32'(m_axis_tdata), 32'h01);
        drain("ovf");
        check("ovf_sticky", 32'(o_overflow), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(o_overflow), 32'd0);

        // Full FIFO with simultaneous push and pop
        IMAGE_WIDTH = 16'd16;
        for (int i = 1; i <= 16; i++) begin
            push(8'(8'h40 + i), (i == 1), (i == 1), (i == 16), 1'b1);
        end
        check("full_level", 32'(o_fifo_level), 32'd16);
        m_axis_tready = 1'b1;
        push(8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        m_axis_tready = 1'b0;
        check("full_pp_level",    32'(o_fifo_level), 32'd16);
        check("full_pp_overflow", 32'(o_overflow),   32'd0);
        check("full_pp_head",     32'(m_axis_tdata), 32'h42);
        drain("full");

        // Mid-line start of frame, width 8
        do_reset();
        IMAGE_WIDTH   = 16'd8;
        m_axis_tready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            push(8'(8'h50 + i), (i == 0 || i == 5), (i == 0 || i == 5), (i == 12), 1'b1);
        end
        drain("midsof");

        // Width 0 behaves as width 1: every beat is end of line
        IMAGE_WIDTH   = 16'd0;
        push(8'hA1, 1'b1, 1'b1, 1'b1, 1'b1);
        push(8'hA2, 1'b0, 1'b0, 1'b1, 1'b1);
        drain("w0");

        // Reset mid-stream with a push presented during reset
        do_reset();
        IMAGE_WIDTH = 16'd8;
        for (int i = 1; i <= 5; i++) begin
            push(8'(8'h60 + i), (i == 1), (i == 1), 1'b0, 1'b1);
        end
        check("mrst_level5", 32'(o_fifo_level), 32'd5);
        i_aresetn        = 1'b0;
        i_data           = 8'hEE;
        i_start_of_frame = 1'b1;
        i_data_valid     = 1'b1;
        @(posedge i_clk); #1;
        i_aresetn        = 1'b1;
        i_data_valid     = 1'b0;
        i_start_of_frame = 1'b0;
        exp_q.delete();
        check("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mrst_level",  32'(o_fifo_level),  32'd0);
        check("mrst_tdata",  32'(m_axis_tdata),  32'd0);
        @(posedge i_clk); #1;
        check("mrst_ignored_push", 32'(m_axis_tvalid), 32'd0);
        m_axis_tready = 1'b1;
        push(8'h77, 1'b1, 1'b1, 1'b0, 1'b1);
        drain("mrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pixel_transmitter.md
AXIS_PIXEL_TRANSMITTER -- requirements
Module: axis_pixel_transmitter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the pixel width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the output FIFO depth; legal values are powers of two, 4 or more.
REQ-003 The block SHALL have the following ports, one per line:
- i_clk  input  1  single clock; all logic on its rising edge
- i_aresetn  input  1  synchronous, active-low reset
- IMAGE_WIDTH  input  16  pixels per line (runtime)
- i_data  input  DATA_WIDTH  filtered pixel from the median stage
- i_data_valid  input  1  i_data is valid this cycle; no backpressure upstream
- i_start_of_frame  input  1  qualifies the first pixel of a frame; only meaningful with i_data_valid
- m_axis_tdata  output  DATA_WIDTH  AXI4-Stream data
- m_axis_tvalid  output  1  AXI4-Stream valid
- m_axis_tready  input  1  AXI4-Stream ready
- m_axis_tuser  output  1  start of frame
- m_axis_tlast  output  1  end of line
- o_fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_overflow  output  1  sticky pixel-drop flag

Function
REQ-004 The block SHALL write {i_start_of_frame, i_data} into a FIFO_DEPTH-entry FIFO on every cycle with i_data_valid=1 ("push"), subject to REQ-007.
REQ-005 The block SHALL drive m_axis_tvalid=1 whenever the FIFO is non-empty, with m_axis_tdata and m_axis_tuser taken from the head entry.
REQ-006 A "pop" SHALL occur on a cycle with m_axis_tvalid=1 and m_axis_tready=1; the head entry is removed at that edge.
REQ-007 The block SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-008 On a push to a full FIFO with no pop in the same cycle, the block SHALL drop the pixel, leave the FIFO unchanged, and set o_overflow=1 at the next edge.
REQ-009 o_overflow SHALL stay 1 until reset.
REQ-010 Latency SHALL be exactly one cycle: a push into an empty FIFO at edge N gives m_axis_tvalid=1 with that pixel in the cycle after edge N.
REQ-011 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL hold stable and m_axis_tvalid SHALL stay 1.
REQ-012 A simultaneous push and pop SHALL leave o_fifo_level unchanged.
REQ-013 Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.
REQ-014 The block SHALL keep an output column counter col (16 bit) that advances only on pops.
REQ-015 The head beat's column SHALL be 0 if m_axis_tuser=1, otherwise col.
REQ-016 m_axis_tlast SHALL be 1 when the head beat's column is ≥ IMAGE_WIDTH-1, compared combinationally against the live IMAGE_WIDTH.
REQ-017 IMAGE_WIDTH = 0 SHALL be treated as 1, so every beat has m_axis_tlast=1.
REQ-018 On a pop, col SHALL become 0 if the popped beat had m_axis_tlast=1, otherwise (beat column + 1).
REQ-019 A tuser beat arriving mid-line SHALL restart the column count at 0; the truncated previous line receives no tlast.
REQ-020 m_axis_tlast and m_axis_tuser SHALL be 0 whenever m_axis_tvalid=0.

Reset
REQ-021 Reset SHALL be evaluated only on a rising edge of i_clk with i_aresetn=0.
REQ-022 Reset SHALL give m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, o_fifo_level=0, o_overflow=0, col=0, and both FIFO pointers at 0.
REQ-023 Reset asserted mid-stream SHALL flush all FIFO contents, so no pre-reset beat is emitted after reset is released.
REQ-024 Pushes presented while i_aresetn=0 SHALL be ignored.

Verification
REQ-025 Basic stream: IMAGE_WIDTH=4, tready=1, 8 pixels 0x01..0x08 with SOF on the first -> the same 8 beats one cycle later; tuser on 0x01 only; tlast on 0x04 and 0x08.
REQ-026 Backpressure: tready=0 for 10 cycles while 6 pixels are pushed -> o_fifo_level=6, head 0x01 held stable, then 6 beats in order once tready=1, no overflow.
REQ-027 Overflow: FIFO_DEPTH=16, tready=0, 18 pushes -> level 16, o_overflow=1 from the cycle after push 17, and the output is pixels 1..16 only.
REQ-028 Full with simultaneous push and pop: with the FIFO full, tready=1 and one push -> level stays 16, pixel accepted, o_overflow stays 0.
REQ-029 Mid-line SOF: IMAGE_WIDTH=8, SOF at pixels 0 and 5 -> no tlast in pixels 0..4; tlast on pixel 12 (column 7 of the new frame).
REQ-030 Reset mid-stream: assert i_aresetn=0 for 1 edge with level=5 -> tvalid=0, level=0 next cycle; the next pushed pixel appears alone with correct tuser.
